// File: rtl/clk_ctrl_pkg.sv
// Shared types and default timing for the divider speed-change sequencer.
package clk_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_QUIESCE,
        ST_HOLD_RST,
        ST_SETTLE,
        ST_DONE
    } state_t;

    localparam logic [1:0] GEN_SPD_00   = 2'b00;
    localparam logic [1:0] GEN_SPD_01   = 2'b01;
    localparam logic [1:0] GEN_SPD_10   = 2'b10;
    localparam logic [1:0] GEN_SPD_RSVD = 2'b11;

    localparam logic [1:0] DEF_SPEED           = GEN_SPD_00;
    localparam int         DEF_RST_HOLD_CYCLES = 8;
    // Must cover at least one slowest enc_clk period (132 local_clk cycles).
    localparam int         DEF_SETTLE_CYCLES   = 160;
    localparam int         DEF_QUIESCE_TIMEOUT = 1024;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/clk_ctrl_timer.sv
// Shared up-counter: cleared on request, flags when it equals the current terminal value.
module clk_ctrl_timer #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         clear,
    input  logic [W-1:0] limit,
    output logic         at_limit
);

    logic [W-1:0] count_reg;

    // Every owner clears on its terminal count, so the counter never wraps.
    always_ff @(posedge clk) begin
        if (srst || clear) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign at_limit = (count_reg == limit);

endmodule

// File: rtl/clk_speed_ctrl.sv
// Sequences divider ratio changes: quiesce datapath, hold divider in reset, settle, report.
module clk_speed_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter logic [1:0] DEFAULT_SPEED   = DEF_SPEED,
    parameter int         RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
    parameter int         SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter int         QUIESCE_TIMEOUT = DEF_QUIESCE_TIMEOUT
) (
    input  logic       local_clk,
    input  logic       rst,
    input  logic       speed_req_valid,
    input  logic [1:0] speed_req,
    output logic       speed_req_ready,
    input  logic       link_idle,
    output logic       quiesce_req,
    output logic [1:0] div_gen_speed,
    output logic       div_rst_n,
    output logic [1:0] cur_speed,
    output logic       busy,
    output logic       speed_done,
    output logic       speed_err
);

    localparam int CNT_W = $clog2(max3(QUIESCE_TIMEOUT, SETTLE_CYCLES, RST_HOLD_CYCLES) + 1);
    localparam logic [CNT_W-1:0] HOLD_LIM    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LIM  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(QUIESCE_TIMEOUT - 1);

    state_t           state_reg;
    logic [1:0]       target_reg;
    logic [1:0]       div_gen_speed_reg;
    logic [1:0]       cur_speed_reg;
    logic             div_rst_n_reg;
    logic             quiesce_req_reg;
    logic             ready_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             err_reg;

    logic [CNT_W-1:0] limit;
    logic             at_limit;
    logic             timer_clear;

    // INIT reuses div_rst_n as its phase bit: low = hold phase, high = settle phase.
    always_comb begin
        limit = '0;
        case (state_reg)
            ST_INIT:     limit = div_rst_n_reg ? SETTLE_LIM : HOLD_LIM;
            ST_QUIESCE:  limit = TIMEOUT_LIM;
            ST_HOLD_RST: limit = HOLD_LIM;
            ST_SETTLE:   limit = SETTLE_LIM;
            default:     limit = '0;
        endcase
    end

    // Clear on every state/phase exit so each timed interval starts from zero.
    assign timer_clear = at_limit
                      || (state_reg == ST_IDLE)
                      || (state_reg == ST_DONE)
                      || ((state_reg == ST_QUIESCE) && link_idle);

    clk_ctrl_timer #(
        .W(CNT_W)
    ) u_timer (
        .clk      (local_clk),
        .srst     (rst),
        .clear    (timer_clear),
        .limit    (limit),
        .at_limit (at_limit)
    );

    always_ff @(posedge local_clk) begin
        if (rst) begin
            state_reg         <= ST_INIT;
            target_reg        <= DEFAULT_SPEED;
            div_gen_speed_reg <= DEFAULT_SPEED;
            cur_speed_reg     <= DEFAULT_SPEED;
            div_rst_n_reg     <= 1'b0;
            quiesce_req_reg   <= 1'b0;
            ready_reg         <= 1'b0;
            busy_reg          <= 1'b1;
            done_reg          <= 1'b0;
            err_reg           <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                ST_INIT: begin
                    if (at_limit) begin
                        if (!div_rst_n_reg) begin
                            div_rst_n_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_IDLE;
                            ready_reg <= 1'b1;
                            busy_reg  <= 1'b0;
                        end
                    end
                end
                ST_IDLE: begin
                    if (speed_req_valid && ready_reg) begin
                        if (speed_req == GEN_SPD_RSVD) begin
                            err_reg <= 1'b1;
                        end else if (speed_req == cur_speed_reg) begin
                            state_reg  <= ST_DONE;
                            target_reg <= speed_req;
                            ready_reg  <= 1'b0;
                            busy_reg   <= 1'b1;
                            done_reg   <= 1'b1;
                        end else begin
                            state_reg       <= ST_QUIESCE;
                            target_reg      <= speed_req;
                            quiesce_req_reg <= 1'b1;
                            ready_reg       <= 1'b0;
                            busy_reg        <= 1'b1;
                        end
                    end
                end
                ST_QUIESCE: begin
                    // Ratio only moves on the same edge that drops the divider reset.
                    if (link_idle) begin
                        state_reg         <= ST_HOLD_RST;
                        div_gen_speed_reg <= target_reg;
                        div_rst_n_reg     <= 1'b0;
                    end else if (at_limit) begin
                        state_reg       <= ST_IDLE;
                        quiesce_req_reg <= 1'b0;
                        err_reg         <= 1'b1;
                        ready_reg       <= 1'b1;
                        busy_reg        <= 1'b0;
                    end
                end
                ST_HOLD_RST: begin
                    if (at_limit) begin
                        state_reg     <= ST_SETTLE;
                        div_rst_n_reg <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (at_limit) begin
                        state_reg       <= ST_DONE;
                        done_reg        <= 1'b1;
                        cur_speed_reg   <= target_reg;
                        quiesce_req_reg <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    ready_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_INIT;
                end
            endcase
        end
    end

    assign speed_req_ready = ready_reg;
    assign quiesce_req     = quiesce_req_reg;
    assign div_gen_speed   = div_gen_speed_reg;
    assign div_rst_n       = div_rst_n_reg;
    assign cur_speed       = cur_speed_reg;
    assign busy            = busy_reg;
    assign speed_done      = done_reg;
    assign speed_err       = err_reg;

endmodule

// File: tb/tb_clk_speed_ctrl.sv
// Directed plus randomized bench for clk_speed_ctrl against a request-level timing model.
module tb_clk_speed_ctrl;

    localparam int RH    = 8;
    localparam int SC    = 160;
    localparam int QT    = 1024;
    localparam int NEVER = 100000;

    logic       local_clk = 1'b0;
    logic       rst = 1'b1;
    logic       speed_req_valid = 1'b0;
    logic [1:0] speed_req = 2'b00;
    logic       speed_req_ready;
    logic       link_idle = 1'b0;
    logic       quiesce_req;
    logic [1:0] div_gen_speed;
    logic       div_rst_n;
    logic [1:0] cur_speed;
    logic       busy;
    logic       speed_done;
    logic       speed_err;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] m_cur = 2'b00;
    logic [1:0] m_gen = 2'b00;

    always #5 local_clk = ~local_clk;

    clk_speed_ctrl #(
        .DEFAULT_SPEED   (2'b00),
        .RST_HOLD_CYCLES (RH),
        .SETTLE_CYCLES   (SC),
        .QUIESCE_TIMEOUT (QT)
    ) dut (
        .local_clk       (local_clk),
        .rst             (rst),
        .speed_req_valid (speed_req_valid),
        .speed_req       (speed_req),
        .speed_req_ready (speed_req_ready),
        .link_idle       (link_idle),
        .quiesce_req     (quiesce_req),
        .div_gen_speed   (div_gen_speed),
        .div_rst_n       (div_rst_n),
        .cur_speed       (cur_speed),
        .busy            (busy),
        .speed_done      (speed_done),
        .speed_err       (speed_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse reset, then verify reset values and the INIT hold/settle timeline.
    task automatic reset_and_check_init();
        int first_hi = -1;
        int first_rdy = -1;
        int lows = 0;
        int dones = 0;
        @(negedge local_clk);
        rst = 1'b1;
        speed_req_valid = 1'b0;
        link_idle = 1'b0;
        @(negedge local_clk);
        rst = 1'b0;
        check("rst_div_rst_n", div_rst_n, 0);
        check("rst_div_gen", div_gen_speed, 0);
        check("rst_cur_speed", cur_speed, 0);
        check("rst_quiesce", quiesce_req, 0);
        check("rst_ready", speed_req_ready, 0);
        check("rst_busy", busy, 1);
        check("rst_err", speed_err, 0);
        for (int n = 0; n < 400 && first_rdy < 0; n++) begin
            if (n > 0) @(negedge local_clk);
            if (div_rst_n === 1'b1 && first_hi < 0) first_hi = n;
            if (div_rst_n === 1'b0) lows++;
            if (speed_req_ready === 1'b1) first_rdy = n;
            if (speed_done === 1'b1) dones++;
        end
        check("init_first_div_rst_hi", first_hi, RH);
        check("init_low_cycles", lows, RH);
        check("init_ready_cycle", first_rdy, RH + SC);
        check("init_no_done", dones, 0);
        check("init_busy_idle", busy, 0);
        m_cur = 2'b00;
        m_gen = 2'b00;
        $display("init: div_rst_n high at %0d, ready at %0d", first_hi, first_rdy);
    endtask

    task automatic wait_ready();
        int k = 0;
        @(negedge local_clk);
        while (speed_req_ready !== 1'b1 && k < 50) begin
            @(negedge local_clk);
            k++;
        end
        check("ready_wait", speed_req_ready, 1);
    endtask

    // One request; link_idle rises after d QUIESCE cycles (d >= QT means never).
    task automatic do_req(input logic [1:0] req, input int d);
        logic       exp_done, exp_err, exp_q1;
        int         exp_lat, exp_low;
        logic [1:0] exp_cur, exp_gen;
        int         n = 0, low = 0, bad_gen = 0, lat = 0;
        logic       got = 1'b0, q1 = 1'b0;
        logic       o_done = 1'b0, o_err = 1'b0, o_q = 1'b1, o_rdy = 1'b0, o_busy = 1'b0;
        logic [1:0] prev_gen, o_cur, o_gen;

        exp_cur = m_cur;
        exp_gen = m_gen;
        exp_low = 0;
        exp_q1  = 1'b0;
        if (req == 2'b11) begin
            exp_done = 1'b0; exp_err = 1'b1; exp_lat = 1;
        end else if (req == m_cur) begin
            exp_done = 1'b1; exp_err = 1'b0; exp_lat = 1;
        end else if (d < QT) begin
            exp_done = 1'b1; exp_err = 1'b0; exp_lat = 2 + d + RH + SC;
            exp_cur = req; exp_gen = req; exp_low = RH; exp_q1 = 1'b1;
        end else begin
            exp_done = 1'b0; exp_err = 1'b1; exp_lat = QT + 1; exp_q1 = 1'b1;
        end

        wait_ready();
        speed_req_valid = 1'b1;
        speed_req = req;
        link_idle = 1'b0;
        prev_gen = div_gen_speed;
        o_cur = cur_speed;
        o_gen = div_gen_speed;
        @(posedge local_clk);
        while (!got && n < 1300) begin
            @(negedge local_clk);
            n++;
            speed_req_valid = 1'b0;
            if (div_rst_n === 1'b0) low++;
            if (div_gen_speed !== prev_gen && div_rst_n !== 1'b0) bad_gen++;
            prev_gen = div_gen_speed;
            if (n == 1) q1 = quiesce_req;
            if (speed_done === 1'b1 || speed_err === 1'b1) begin
                got = 1'b1;
                lat = n;
                o_done = speed_done;
                o_err = speed_err;
                o_cur = cur_speed;
                o_gen = div_gen_speed;
                o_q = quiesce_req;
                o_rdy = speed_req_ready;
                o_busy = busy;
            end else begin
                link_idle = (n >= 1 + d);
            end
        end
        link_idle = 1'b0;

        check("req_latency", lat, exp_lat);
        check("req_done", o_done, exp_done);
        check("req_err", o_err, exp_err);
        check("req_cur_speed", o_cur, exp_cur);
        check("req_div_gen", o_gen, exp_gen);
        check("req_quiesce_end", o_q, 0);
        check("req_quiesce_c1", q1, exp_q1);
        check("req_rst_low_cycles", low, exp_low);
        check("req_gen_while_running", bad_gen, 0);
        check("req_ready_end", o_rdy, exp_err);
        check("req_busy_end", o_busy, exp_done);
        m_cur = exp_cur;
        m_gen = exp_gen;
        $display("req=%0d idle_after=%0d lat=%0d done=%0d err=%0d cur=%0d",
                 req, d, lat, o_done, o_err, o_cur);
    endtask

    // Reset in SETTLE of a change away from a non-default committed speed.
    task automatic reset_in_settle();
        wait_ready();
        speed_req_valid = 1'b1;
        speed_req = 2'b01;
        link_idle = 1'b1;
        @(posedge local_clk);
        @(negedge local_clk);
        speed_req_valid = 1'b0;
        repeat (49) @(negedge local_clk);
        check("settle_div_gen", div_gen_speed, 1);
        check("settle_quiesce", quiesce_req, 1);
        check("settle_div_rst_n", div_rst_n, 1);
        check("settle_cur_speed", cur_speed, 2);
        $display("reset asserted during SETTLE");
        reset_and_check_init();
    endtask

    // Requester holds valid across a sequence and swaps its value; second one must wait.
    task automatic held_valid(input logic [1:0] a, input logic [1:0] b);
        int         n = 0, first = -1, second = -1, rdy_busy = 0;
        logic [1:0] cur_a = 2'b00;
        wait_ready();
        speed_req_valid = 1'b1;
        speed_req = a;
        link_idle = 1'b1;
        @(posedge local_clk);
        while (second < 0 && n < 800) begin
            @(negedge local_clk);
            n++;
            if (n == 1) speed_req = b;
            if (first < 0 && speed_req_ready === 1'b1) rdy_busy++;
            if (speed_done === 1'b1) begin
                if (first < 0) begin
                    first = n;
                    cur_a = cur_speed;
                end else begin
                    second = n;
                end
            end
            if (n == RH + SC + 4) speed_req_valid = 1'b0;
        end
        speed_req_valid = 1'b0;
        link_idle = 1'b0;
        check("held_first_done", first, 2 + RH + SC);
        check("held_first_cur", cur_a, a);
        check("held_ready_while_busy", rdy_busy, 0);
        check("held_second_done", second, 2 * (2 + RH + SC) + 1);
        check("held_second_cur", cur_speed, b);
        m_cur = b;
        m_gen = b;
        $display("held valid: a=%0d done@%0d b=%0d done@%0d", a, first, b, second);
    endtask

    initial begin
        logic [1:0] a, b, r;
        int         sel, d;

        reset_and_check_init();
        do_req(2'b01, NEVER);
        do_req(2'b10, 0);
        do_req(2'b10, 0);
        do_req(2'b11, 0);
        reset_in_settle();
        do_req(2'b01, QT - 1);
        do_req(2'b10, 5);

        a = 2'($urandom_range(0, 2));
        if (a == m_cur) a = (a == 2'd2) ? 2'd0 : a + 2'd1;
        b = 2'($urandom_range(0, 2));
        if (b == a) b = (b == 2'd2) ? 2'd0 : b + 2'd1;
        held_valid(a, b);

        for (int i = 0; i < 12; i++) begin
            r = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 9);
            if (sel < 7) d = $urandom_range(0, 30);
            else if (sel == 7) d = QT - 1;
            else if (sel == 8) d = NEVER;
            else d = 0;
            do_req(r, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
